button_event_reader: RTL and testbench

Input-side companion to the LED pattern driver: samples eight asynchronous push-button/DIP-switch pins on SYSCLK, synchronises and debounces each one, and reports clean levels, single-cycle press/release pulses, and a 4-deep queue of press/release events read through a valid/ready handshake. It sits between the board switch pins and any control logic that consumes user input.

---
 rtl/button_event_reader.sv | 115 +++++++++++
 tb/tb_button_event_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_reader.sv
// button_event_reader: synchronise and debounce eight switch pins, pulse on edges, and queue the events
module button_event_reader #(
    parameter int DEBOUNCE_CYCLES = 25000000 / 50,
    parameter int CNT_WIDTH = 20,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic [7:0] SW,
    output logic [7:0] LEVEL,
    output logic [7:0] PRESS,
    output logic [7:0] RELEASE,
    output logic       EVT_VALID,
    output logic [3:0] EVT_DATA,
    input  logic       EVT_READY,
    output logic       EVT_OVF,
    input  logic       CLR_OVF
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync1, sync2, s, commit, set_pp, set_pr, clr_pp, clr_pr, pp, pr;
    logic [CNT_WIDTH-1:0] cnt [8];
    logic [3:0] mem [4];
    logic [3:0] sel_evt;
    logic [2:0] sel, count;
    logic [1:0] rd_ptr, wr_ptr;
    logic       any_pend, pop, push, ovf_set;

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign set_pp = commit & s;
    assign set_pr = commit & ~s;
    assign EVT_VALID = count != 3'd0;
    assign EVT_DATA = EVT_VALID ? mem[rd_ptr] : 4'd0;

    // two-flop synchroniser on every pin
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    // a channel commits once its differing level has been stable for DEBOUNCE_CYCLES samples
    always_comb begin
        commit = '0;
        for (int i = 0; i < 8; i++) commit[i] = (s[i] != LEVEL[i]) && (cnt[i] == LAST);
    end

    // debounce counters, accepted levels and the one-cycle edge pulses
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            LEVEL   <= '0;
            PRESS   <= '0;
            RELEASE <= '0;
        end else begin
            for (int i = 0; i < 8; i++) cnt[i] <= (s[i] == LEVEL[i] || commit[i]) ? '0 : cnt[i] + 1'b1;
            LEVEL   <= LEVEL ^ commit;
            PRESS   <= set_pp;
            RELEASE <= set_pr;
        end
    end

    // lowest pending channel wins, press before release; a full FIFO still accepts when it pops
    always_comb begin
        sel = '0;
        any_pend = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pp[i] | pr[i]) begin
                sel = 3'(i);
                any_pend = 1'b1;
            end
        end
        sel_evt = {pp[sel], sel};
        pop = EVT_VALID & EVT_READY;
        push = any_pend & (~count[2] | pop);
        clr_pp = (push & pp[sel]) ? 8'b1 << sel : 8'b0;
        clr_pr = (push & ~pp[sel]) ? 8'b1 << sel : 8'b0;
        ovf_set = |(set_pp & pp & ~clr_pp) | |(set_pr & pr & ~clr_pr);
    end

    // pending bits (a new set beats a same-cycle clear) and the sticky overflow flag
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            pp      <= '0;
            pr      <= '0;
            EVT_OVF <= 1'b0;
        end else begin
            pp      <= (pp & ~clr_pp) | set_pp;
            pr      <= (pr & ~clr_pr) | set_pr;
            EVT_OVF <= ovf_set | (EVT_OVF & ~CLR_OVF);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + 2'(pop);
            wr_ptr <= wr_ptr + 2'(push);
            count  <= count + 3'(push) - 3'(pop);
        end
    end

    // FIFO storage; empty slots are masked at the output so they need no reset
    always_ff @(posedge SYSCLK) begin
        if (push) mem[wr_ptr] <= sel_evt;
    end
endmodule

// File: tb/tb_button_event_reader.sv
// tb_button_event_reader: directed scenarios plus random stimulus against a queue-based reference model
module tb_button_event_reader;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] sw = '0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] level, press, rel;
    logic       valid, ovf;
    logic [3:0] data;
    int         checks = 0;
    int         errors = 0;

    // reference model state: sampled-pin delay line, window of recent samples, pending sets, event queue
    logic [7:0] m_d1, m_d2, m_level, m_press, m_rel, m_pp, m_pr;
    logic       m_ovf;
    logic [7:0] m_win [$];
    logic [3:0] m_q [$];

    button_event_reader #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(20), .ACTIVE_LOW(0)) dut (
        .SYSCLK(clk), .RSTN(rstn), .SW(sw), .LEVEL(level), .PRESS(press), .RELEASE(rel),
        .EVT_VALID(valid), .EVT_DATA(data), .EVT_READY(ready), .EVT_OVF(ovf), .CLR_OVF(clr)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_pp = '0; m_pr = '0; m_ovf = 1'b0;
        m_win.delete();
        m_q.delete();
    endfunction

    // advance the model across one rising edge given the inputs presented to it
    function automatic void model_step(input logic [7:0] sw_in, input logic rdy, input logic clr_in);
        logic [7:0] smp, c, npp, npr;
        logic [3:0] ev;
        logic popped, pushed, hit;
        int sel;
        smp = m_d2;
        m_win.push_back(smp);
        if (m_win.size() > D) void'(m_win.pop_front());
        c = '0;
        if (m_win.size() == D)
            for (int i = 0; i < 8; i++) begin
                c[i] = 1'b1;
                foreach (m_win[j]) if (m_win[j][i] == m_level[i]) c[i] = 1'b0;
            end
        popped = (m_q.size() > 0) && rdy;
        sel = -1;
        for (int i = 7; i >= 0; i--) if (m_pp[i] || m_pr[i]) sel = i;
        npp = m_pp; npr = m_pr; ev = '0;
        pushed = (sel >= 0) && (m_q.size() < 4 || popped);
        if (pushed) begin
            ev = {m_pp[sel], 3'(sel)};
            if (m_pp[sel]) npp[sel] = 1'b0; else npr[sel] = 1'b0;
        end
        if (popped) void'(m_q.pop_front());
        if (pushed) m_q.push_back(ev);
        hit = 1'b0;
        for (int i = 0; i < 8; i++) if (c[i]) begin
            if (!m_level[i]) begin hit |= npp[i]; npp[i] = 1'b1; end
            else begin hit |= npr[i]; npr[i] = 1'b1; end
        end
        m_pp = npp; m_pr = npr;
        m_press = c & ~m_level;
        m_rel = c & m_level;
        m_level = m_level ^ c;
        m_ovf = hit | (m_ovf & ~clr_in);
        m_d2 = m_d1;
        m_d1 = sw_in;
    endfunction

    // drive one cycle of inputs at the falling edge and settle just after the rising edge
    task automatic tick(input logic [7:0] s_in, input logic r, input logic c);
        @(negedge clk);
        sw = s_in; ready = r; clr = c;
        model_step(s_in, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] s_hold);
        @(negedge clk);
        rstn = 1'b0; sw = s_hold; ready = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        model_step(s_hold, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] s_in, input logic r, input int n);
        for (int k = 0; k < n; k++) tick(s_in, r, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({level, press, rel, valid, data, ovf} !== 30'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {level, press, rel, valid, data, ovf}); end
        do_reset(8'h00);
        hold(8'h00, 1'b1, 8);
        checks++; if ({level, press, rel, valid, data, ovf} !== 30'd0) begin errors++; $display("FAIL reset_idle: got %h want 0", {level, press, rel, valid, data, ovf}); end
    endtask

    task automatic test_clean_press();
        do_reset(8'h00);
        hold(8'h04, 1'b1, 5);
        checks++; if (level !== 8'h00 || press !== 8'h00) begin errors++; $display("FAIL press_early: level %h press %h want 00 00", level, press); end
        tick(8'h04, 1'b1, 1'b0);
        checks++; if (level !== 8'h04 || press !== 8'h04 || rel !== 8'h00) begin errors++; $display("FAIL press_commit: level %h press %h rel %h want 04 04 00", level, press, rel); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL press_valid_early: got %b want 0", valid); end
        tick(8'h04, 1'b1, 1'b0);
        checks++; if (press !== 8'h00) begin errors++; $display("FAIL press_pulse_width: got %h want 00", press); end
        checks++; if (valid !== 1'b1 || data !== 4'b1010) begin errors++; $display("FAIL press_event: valid %b data %b want 1 1010", valid, data); end
        tick(8'h04, 1'b1, 1'b0);
        checks++; if (valid !== 1'b0 || level !== 8'h04) begin errors++; $display("FAIL press_popped: valid %b level %h want 0 04", valid, level); end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [4];
        int np, nr, at, nv;
        seq = '{8'h01, 8'h00, 8'h01, 8'h00};
        do_reset(8'h00);
        np = 0; nr = 0; at = -1; nv = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(k <= 4 ? seq[k-1] : 8'h01, 1'b1, 1'b0);
            if (press[0]) begin np++; at = k; end
            if (rel[0]) nr++;
            if (valid && data === 4'b1000) nv++;
        end
        checks++; if (np !== 1 || nr !== 0) begin errors++; $display("FAIL bounce_pulses: press %0d release %0d want 1 0", np, nr); end
        checks++; if (at !== 10) begin errors++; $display("FAIL bounce_latency: press at tick %0d want 10", at); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL bounce_events: %0d cycles with 1000 want 1", nv); end
    endtask

    task automatic test_simultaneous();
        do_reset(8'h00);
        hold(8'h22, 1'b0, 6);
        checks++; if (press !== 8'h22) begin errors++; $display("FAIL simul_press: got %h want 22", press); end
        hold(8'h22, 1'b0, 2);
        checks++; if (valid !== 1'b1 || data !== 4'b1001) begin errors++; $display("FAIL simul_head: valid %b data %b want 1 1001", valid, data); end
        tick(8'h22, 1'b1, 1'b0);
        checks++; if (valid !== 1'b1 || data !== 4'b1101) begin errors++; $display("FAIL simul_second: valid %b data %b want 1 1101", valid, data); end
        tick(8'h22, 1'b1, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b want 0", valid); end
    endtask

    task automatic fill_ch3();
        hold(8'h08, 1'b0, 6);
        hold(8'h00, 1'b0, 6);
        hold(8'h08, 1'b0, 6);
        hold(8'h00, 1'b0, 6);
        hold(8'h08, 1'b0, 6);
    endtask

    task automatic test_overflow();
        logic [3:0] got [8];
        logic [3:0] exp_seq [6];
        int n;
        exp_seq = '{4'b1011, 4'b0011, 4'b1011, 4'b0011, 4'b1011, 4'b0011};
        do_reset(8'h00);
        fill_ch3();
        hold(8'h00, 1'b0, 6);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
        hold(8'h08, 1'b0, 6);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        checks++; if (valid !== 1'b1 || data !== 4'b1011) begin errors++; $display("FAIL ovf_head: valid %b data %b want 1 1011", valid, data); end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (valid && n < 8) begin got[n] = data; n++; end
            tick(8'h08, 1'b1, 1'b0);
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL ovf_drain_count: got %0d want 6", n); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (k < n && got[k] !== exp_seq[k]) begin errors++; $display("FAIL ovf_drain_%0d: got %b want %b", k, got[k], exp_seq[k]); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        tick(8'h08, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_seq [4];
        int n, bad;
        exp_seq = '{4'b0011, 4'b1011, 4'b0011, 4'b1011};
        do_reset(8'h00);
        fill_ch3();
        tick(8'h08, 1'b1, 1'b0);
        checks++; if (valid !== 1'b1 || data !== 4'b0011) begin errors++; $display("FAIL full_head: valid %b data %b want 1 0011", valid, data); end
        hold(8'h08, 1'b0, 3);
        checks++; if (data !== 4'b0011 || ovf !== 1'b0) begin errors++; $display("FAIL full_stable: data %b ovf %b want 0011 0", data, ovf); end
        n = 0; bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (valid) begin
                if (n >= 4 || data !== exp_seq[n]) bad++;
                n++;
            end
            tick(8'h08, 1'b1, 1'b0);
        end
        checks++; if (n !== 4 || bad !== 0) begin errors++; $display("FAIL full_drain: %0d events %0d wrong want 4 0", n, bad); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(8'h00);
        hold(8'h81, 1'b0, 8);
        checks++; if (valid !== 1'b1 || data !== 4'b1000) begin errors++; $display("FAIL mid_before: valid %b data %b want 1 1000", valid, data); end
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        checks++; if ({level, press, rel, valid, data, ovf} !== 30'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", {level, press, rel, valid, data, ovf}); end
        @(negedge clk);
        rstn = 1'b1;
        model_step(8'h81, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n = 1;
        while (!press[7] && n < 12) begin tick(8'h81, 1'b0, 1'b0); n++; end
        checks++; if (!press[7] || n < 5 || n > 7) begin errors++; $display("FAIL mid_repress: press at cycle %0d want 6", n); end
        hold(8'h81, 1'b0, 2);
        tick(8'h81, 1'b1, 1'b0);
        checks++; if (valid !== 1'b1 || data !== 4'b1111) begin errors++; $display("FAIL mid_event: valid %b data %b want 1 1111", valid, data); end
    endtask

    task automatic test_random();
        logic [7:0] cur, flip;
        logic [3:0] m_data;
        int rp;
        do_reset(8'h00);
        cur = '0; rp = 50;
        for (int k = 0; k < 4000; k++) begin
            if (k % 200 == 0) rp = $urandom_range(5, 95);
            flip = 8'b1 << $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) cur = cur ^ flip;
            tick(cur, $urandom_range(0, 99) < rp, $urandom_range(0, 63) == 0);
            m_data = (m_q.size() > 0) ? m_q[0] : 4'd0;
            checks++; if (level !== m_level) begin errors++; $display("FAIL rnd_level @%0d: got %h want %h", k, level, m_level); end
            checks++; if (press !== m_press || rel !== m_rel) begin errors++; $display("FAIL rnd_pulses @%0d: got %h/%h want %h/%h", k, press, rel, m_press, m_rel); end
            checks++; if (valid !== (m_q.size() > 0) || data !== m_data) begin errors++; $display("FAIL rnd_event @%0d: got %b %b want %b %b", k, valid, data, m_q.size() > 0, m_data); end
            checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf @%0d: got %b want %b", k, ovf, m_ovf); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
